// File: rtl/ir_pkg.sv
// Shared IR definitions: transmitter FSM states and the carrier timing defaults
// used by both the transmitter and the receiver bench.
package ir_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int DEF_CNT_WIDTH    = 25;
  localparam int DEF_CARRIER_DIV  = 316;
  localparam int DEF_CARRIER_HIGH = 105;

endpackage

// File: rtl/ir_carrier.sv
// Carrier generator: free-running phase counter while the envelope is high,
// with a registered duty compare so the output lines up with the envelope flop.
module ir_carrier
  import ir_pkg::*;
#(
  parameter int DIV  = DEF_CARRIER_DIV,
  parameter int HIGH = DEF_CARRIER_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic carrier
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] HIGH_C = CW'(HIGH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Phase is evaluated for the upcoming cycle so carrier and envelope switch together.
  always_comb begin
    cnt_next = '0;
    if (en && !restart) begin
      cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      carrier <= en && (cnt_next < HIGH_C);
    end
  end

endmodule

// File: rtl/ir_tx.sv
// IR transmitter: plays (level, length) segments from a valid/ready stream onto
// the LED line, optionally modulated by the carrier.
module ir_tx
  import ir_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int CARRIER_DIV  = DEF_CARRIER_DIV,
  parameter int CARRIER_HIGH = DEF_CARRIER_HIGH,
  parameter bit MOD_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  input  logic                 seg_level,
  input  logic [CNT_WIDTH-1:0] seg_len,
  output logic                 pulse,
  output logic                 tx,
  output logic                 busy
);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [CNT_WIDTH-1:0] last, last_next;
  logic [CNT_WIDTH-1:0] seg_last;
  logic                 pulse_next;
  logic                 at_end;
  logic                 take;
  logic                 carrier;

  // A zero length plays as a single cycle, so it shares the last index of length 1.
  assign seg_last  = (seg_len == '0) ? '0 : seg_len - 1'b1;
  assign at_end    = (state == SEND) && (cnt == last);
  assign seg_ready = (state == IDLE) || at_end;
  assign take      = seg_valid && seg_ready;
  assign busy      = (state == SEND);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    last_next  = last;
    pulse_next = pulse;
    case (state)
      IDLE: begin
        pulse_next = 1'b0;
        if (take) begin
          state_next = SEND;
          cnt_next   = '0;
          last_next  = seg_last;
          pulse_next = seg_level;
        end
      end
      SEND: begin
        if (take) begin
          cnt_next   = '0;
          last_next  = seg_last;
          pulse_next = seg_level;
        end else if (at_end) begin
          state_next = IDLE;
          cnt_next   = '0;
          pulse_next = 1'b0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        pulse_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
      pulse <= pulse_next;
    end
  end

  // Restart only on a rising envelope so back-to-back marks keep carrier phase.
  ir_carrier #(
    .DIV  (CARRIER_DIV),
    .HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pulse_next),
    .restart (pulse_next && !pulse),
    .carrier (carrier)
  );

  assign tx = MOD_EN ? carrier : pulse;

endmodule

// File: doc/ir_tx.md
Name: ir_tx

Overview:
IR transmitter. It is the transmit-side counterpart of the IR receiver, which measures pulse durations in clk cycles. It takes a stream of (level, length) segments over a valid/ready handshake and plays each segment onto the IR LED line as an envelope. When the envelope is high and modulation is enabled, the line carries a carrier of programmable period and duty. It sits between a command encoder (NEC/RC5 framer or CPU FIFO) and the LED driver pin.

Parameters:
CNT_WIDTH, 25, width of segment length in clk cycles (same as receiver counter width)
CARRIER_DIV, 316, carrier period in clk cycles (12 MHz / 38 kHz); must be >= 2
CARRIER_HIGH, 105, carrier high cycles per period (~1/3 duty); 1 <= CARRIER_HIGH < CARRIER_DIV
MOD_EN, 1, 1 = tx is envelope AND carrier; 0 = tx equals envelope (raw loopback mode)

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
seg_valid  input  1  segment offered
seg_ready  output  1  block can accept a segment this cycle
seg_level  input  1  envelope level of segment (1 = mark, 0 = space)
seg_len  input  CNT_WIDTH  segment duration in clk cycles (0 treated as 1)
pulse  output  1  registered envelope
tx  output  1  registered LED drive (modulated envelope)
busy  output  1  a segment is being played

Behaviour:
- Reset (async assert, sync release): state=IDLE, pulse=0, tx=0, busy=0, carrier counter=0, duration counter=0. seg_ready=1 from the first cycle after release.
- Transfer occurs when seg_valid && seg_ready at a rising edge. seg_level/seg_len are sampled only then.
- States:
  - IDLE: seg_ready=1, pulse=0, tx=0. On transfer -> SEND.
  - SEND: busy=1. The duration counter counts from 0 to L-1, where L = max(seg_len,1).
- Latency: a segment transferred at edge k drives pulse=seg_level on cycles k+1 .. k+L inclusive.
- seg_ready in SEND is 1 only in the final cycle of the current segment (counter==L-1). A transfer in that cycle starts the next segment with zero gap.
- No transfer in the final cycle: -> IDLE, pulse=0 from the next cycle. This idle space is not counted by the block.
- Carrier counter:
  - Held at 0 while pulse=0.
  - Loads 0 on the first cycle pulse becomes 1 after being 0.
  - Increments each cycle while pulse=1 and wraps CARRIER_DIV-1 -> 0.
  - Consecutive mark segments keep carrier phase (no restart).
- tx = pulse && (carrier_cnt < CARRIER_HIGH) when MOD_EN=1, else tx = pulse. tx and pulse are updated on the same edge (no skew). tx is glitch-free (registered).
- Reset mid-segment: outputs go 0 immediately (async). The in-flight segment is discarded, not resumed.
- Length arithmetic is unsigned CNT_WIDTH. The maximum segment is 2^CNT_WIDTH-1 cycles; there is no overflow path.

Decomposition:
- Package ir_pkg:
  - state enum (IDLE, SEND)
  - default CNT_WIDTH
  - carrier constants CARRIER_DIV/CARRIER_HIGH, shared with the receiver bench
- Sub-module ir_carrier: counter plus duty compare, with inputs clk, rst_n, en (next pulse), restart (rising envelope), and output carrier.
- ir_tx holds the handshake FSM, the duration counter and the output registers.

Test Plan (bench uses CARRIER_DIV=4, CARRIER_HIGH=2 unless noted):
1. Hold rst_n=0 for 5 cycles, then release -> pulse=0, tx=0, busy=0, seg_ready=1. Stay idle 10 cycles with seg_valid=0 -> outputs unchanged.
2. Single segment (1,10) transferred at edge 0 -> pulse=1 on cycles 1..10; tx = 1100110011; cycle 11: pulse=0, tx=0, busy=0, seg_ready=1.
3. Back-to-back (1,5),(0,3),(1,2) with seg_valid held -> pulse = 11111 000 11 with no gaps; tx = 11001 000 11 (carrier restarts on second mark); seg_ready high exactly in cycles 5, 8, 10.
4. Segments (1,0) then (1,3) -> first segment lasts 1 cycle; pulse = 1 111; carrier phase continuous, so tx = 1 100.
5. Segment (1,100) with rst_n pulsed low at cycle 40 -> pulse/tx drop to 0 asynchronously. After release, the block is IDLE, and a new (1,4) plays exactly 4 cycles.
6. Loopback with MOD_EN=0: tx feeds the receiver with (1,100),(0,50),(1,30) -> receiver edges occur 100 and 50 cycles apart. The receiver's cnt is 99, then 49, on the cycle before each successive edge.
